// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU issue sequencer and the future decode stage:
// sequencer states, ALU FunSel encodings and FlagsOut bit positions.
package alu_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ISSUE_LO = 3'd1,
      S_ISSUE_HI = 3'd2,
      S_FLAGS    = 3'd3,
      S_RESP     = 3'd4
   } seq_state_e;

   // ALU FunSel encodings
   localparam logic [4:0] FUNSEL_PASS_A = 5'b10000;
   localparam logic [4:0] FUNSEL_IDLE   = FUNSEL_PASS_A;
   localparam logic [4:0] FUNSEL_ADD32  = 5'b10100;
   localparam logic [4:0] FUNSEL_ADC32  = 5'b10101;
   localparam logic [4:0] FUNSEL_SUB32  = 5'b10110;

   // FlagsOut is {Z,C,N,V}
   localparam int FLAG_Z = 3;
   localparam int FLAG_C = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_op_sequencer.sv
// Issue stage in front of the 32-bit ALU. Accepts one request at a time,
// runs it through the ALU (two chained passes for 64-bit adds), captures the
// result and the registered ALU flags, and returns them over valid/ready.
// Build option: define ALU_SEQ_WF_BYPASS_EN to let single operations with
// WF=0 skip the FLAGS cycle (flags are unchanged, so they are sampled early).
module alu_op_sequencer
   import alu_seq_pkg::*;
(
   input  logic        Clock,
   input  logic        Reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wide,
   input  logic [4:0]  req_funsel,
   input  logic        req_wf,
   input  logic [63:0] req_a,
   input  logic [63:0] req_b,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [4:0]  alu_funsel,
   output logic        alu_wf,
   input  logic [31:0] alu_out,
   input  logic [3:0]  alu_flags,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_data,
   output logic [3:0]  resp_flags
);

   seq_state_e  state_q, state_d;
   logic        wide_q, wide_d;
   logic [4:0]  funsel_q, funsel_d;
   logic        wf_q, wf_d;
   logic [63:0] a_q, a_d;
   logic [63:0] b_q, b_d;
   logic        lowzero_q, lowzero_d;
   logic [63:0] resp_data_q, resp_data_d;
   logic [3:0]  resp_flags_q, resp_flags_d;

   // Next-state and datapath capture
   always_comb begin
      state_d      = state_q;
      wide_d       = wide_q;
      funsel_d     = funsel_q;
      wf_d         = wf_q;
      a_d          = a_q;
      b_d          = b_q;
      lowzero_d    = lowzero_q;
      resp_data_d  = resp_data_q;
      resp_flags_d = resp_flags_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               wide_d   = req_wide;
               funsel_d = req_funsel;
               wf_d     = req_wf;
               a_d      = req_a;
               b_d      = req_b;
               state_d  = S_ISSUE_LO;
            end
         end
         S_ISSUE_LO: begin
            resp_data_d = {32'd0, alu_out};
            lowzero_d   = (alu_out == 32'd0);
            if (wide_q) begin
               state_d = S_ISSUE_HI;
            end else begin
               state_d = S_FLAGS;
`ifdef ALU_SEQ_WF_BYPASS_EN
               // WF=0 leaves the ALU flags untouched, so they are final now
               if (!wf_q) begin
                  resp_flags_d = alu_flags;
                  state_d      = S_RESP;
               end
`endif
            end
         end
         S_ISSUE_HI: begin
            resp_data_d[63:32] = alu_out;
            state_d            = S_FLAGS;
         end
         S_FLAGS: begin
            // Wide Z must cover both halves; C/N/V come from the high pass
            if (wide_q)
               resp_flags_d = {lowzero_q & alu_flags[FLAG_Z],
                               alu_flags[FLAG_C], alu_flags[FLAG_N], alu_flags[FLAG_V]};
            else
               resp_flags_d = alu_flags;
            state_d = S_RESP;
         end
         S_RESP: begin
            if (resp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ALU drive and handshake outputs, decoded from registered state only
   always_comb begin
      alu_a      = 32'd0;
      alu_b      = 32'd0;
      alu_funsel = FUNSEL_IDLE;
      alu_wf     = 1'b0;
      case (state_q)
         S_ISSUE_LO: begin
            alu_a      = a_q[31:0];
            alu_b      = b_q[31:0];
            alu_funsel = wide_q ? FUNSEL_ADD32 : funsel_q;
            alu_wf     = wide_q | wf_q;
         end
         S_ISSUE_HI: begin
            alu_a      = a_q[63:32];
            alu_b      = b_q[63:32];
            alu_funsel = FUNSEL_ADC32;
            alu_wf     = 1'b1;
         end
         default: ;
      endcase
      req_ready  = (state_q == S_IDLE);
      resp_valid = (state_q == S_RESP);
      resp_data  = resp_data_q;
      resp_flags = resp_flags_q;
   end

   // State and datapath registers, synchronous active-low reset
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state_q      <= S_IDLE;
         wide_q       <= 1'b0;
         funsel_q     <= FUNSEL_IDLE;
         wf_q         <= 1'b0;
         a_q          <= 64'd0;
         b_q          <= 64'd0;
         lowzero_q    <= 1'b0;
         resp_data_q  <= 64'd0;
         resp_flags_q <= 4'd0;
      end else begin
         state_q      <= state_d;
         wide_q       <= wide_d;
         funsel_q     <= funsel_d;
         wf_q         <= wf_d;
         a_q          <= a_d;
         b_q          <= b_d;
         lowzero_q    <= lowzero_d;
         resp_data_q  <= resp_data_d;
         resp_flags_q <= resp_flags_d;
      end
   end

endmodule
